onchip_pixel_engine: RTL and testbench
======================================

Name: onchip_pixel_engine

Overview:
- Avalon-MM master that sits directly upstream of the 4096x32 on-chip RAM and drives its second slave port (s2).
- Streams a block of 32-bit words from a source window of the RAM and applies a per-byte pixel operation to each of the 4 pixels in a word.
- Writes the results back to a destination window of the same RAM.
- Offloads simple point filters (copy, invert, threshold, brightness) from the processor cores.

Parameters:
- ADDR_W, 12, word address width; matches the RAM depth of 4096.
- DATA_W, 32, data width; 4 byte-lanes of 8-bit pixels; fixed at 32.
- READ_LATENCY, 1, cycles from the read-address edge to valid mem_readdata; range 1..3.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; launches a job when idle
- src_base  in  12  first source word address
- dst_base  in  12  first destination word address
- word_count  in  13  words to process, 0..4096
- mode  in  2  00 copy, 01 invert, 10 threshold, 11 brighten
- param  in  8  threshold level (mode 10) or brightness offset (mode 11)
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse at job end
- words_done  out  13  words written in the current or last job
- mem_address  out  12  RAM word address
- mem_chipselect  out  1  RAM select
- mem_write  out  1  1 = write, 0 = read
- mem_byteenable  out  4  always 4'hF while chipselect is high
- mem_writedata  out  32  processed word
- mem_readdata  in  32  RAM read data
- mem_clken  out  1  RAM clock enable; constant 1

Behaviour:
- Reset (reset_n low at a clk edge):
  - FSM goes to IDLE.
  - busy, done, mem_chipselect and mem_write are 0; mem_address, mem_writedata and words_done are 0.
  - A reset mid-job aborts the job with no further RAM access; a partially processed job is not resumed.
- Job capture: start is sampled only in IDLE. src_base, dst_base, word_count, mode and param are latched at the accepted start. start while busy is ignored.
- FSM states: IDLE, RD, WT, WR, FIN.
  - IDLE -> RD on start with word_count != 0.
  - IDLE -> FIN on start with word_count == 0; no RAM access occurs.
  - RD, one cycle: chipselect=1, write=0, address = src pointer.
  - WT, READ_LATENCY cycles: chipselect=0. mem_readdata is captured on the last WT cycle.
  - WR, one cycle: chipselect=1, write=1, address = dst pointer, writedata = processed word. Both pointers and words_done increment. If the remaining count reaches 0 -> FIN, else -> RD.
  - FIN, one cycle: done=1, busy=0 on the next cycle, -> IDLE.
- Throughput: 2 + READ_LATENCY cycles per word. With the default latency, a job of N words takes 3N cycles from the start edge to the done pulse, plus 1 cycle.
- busy is 1 in RD, WT and WR. busy is 0 in FIN (the cycle done pulses) and in IDLE.
- Pointer arithmetic: 12-bit modulo 4096. A window that crosses 4095 wraps to 0, with no error. Overlapping source and destination windows are legal: each word is read before it is written, in ascending order.
- Pixel operation: applied independently to byte lanes [7:0], [15:8], [23:16] and [31:24].
  - copy: p.
  - invert: 255 - p.
  - threshold: p >= param ? 255 : 0.
  - brighten: min(p + param, 255), computed in 9 bits and saturated.
- words_done clears to 0 at an accepted start and holds its final value after done.

Optional Feature:
- Macro: ONCHIP_PIXEL_ENGINE_STATS_EN.
- Defined:
  - Adds output ports stat_min (8 bits) and stat_max (8 bits), computed over every output pixel written in the job.
  - They load 8'hFF and 8'h00 at an accepted start and update on each WR cycle.
  - Both read 0 after reset.
  - If word_count is 0, they keep their start values, FF and 00.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- RAM[0x010..0x013] = 0x00FF7F80, 0x01020304, 0x10203040, 0xFFFFFFFF; mode 01, src 0x010, dst 0x100, count 4 -> RAM[0x100..0x103] = 0xFF0080 7F, 0xFEFDFCFB, 0xEFDFCFBF, 0x00000000 (first word 0xFF00807F); done pulses exactly 13 cycles after the start edge; words_done = 4.
- Mode 10, param 0x80, src word 0x7F80FF00 -> destination word 0x00FFFF00. Mode 11, param 0x20, word 0xF0E01000 -> 0xFFFF3020 (saturation).
- Wrap: src 0xFFE, dst 0x7FE, count 4 -> reads 0xFFE, 0xFFF, 0x000, 0x001 and writes 0x7FE..0x801; no address outside 12 bits.
- count 0 -> done pulses one cycle after start, mem_chipselect never asserts, words_done = 0. A second start pulse during a 4-word job is ignored: exactly 4 writes occur.
- reset_n low for 1 cycle during WT of word 2 of 8 -> next cycle busy=0, chipselect=0; only 1 destination word modified; words_done = 0.
- With ONCHIP_PIXEL_ENGINE_STATS_EN, copy of 0x05FA3C11 -> stat_min = 0x05, stat_max = 0xFA.

Source files
------------

// File: rtl/onchip_pixel_engine.sv
// Avalon-MM block engine: reads words from a RAM window, applies a per-byte pixel op, writes back.
// Optional min/max pixel statistics when ONCHIP_PIXEL_ENGINE_STATS_EN is defined.
module onchip_pixel_engine #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   word_count,
    input  logic [1:0]        mode,
    input  logic [7:0]        param,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              mem_clken
`ifdef ONCHIP_PIXEL_ENGINE_STATS_EN
    ,
    output logic [7:0]        stat_min,
    output logic [7:0]        stat_max
`endif
);

    typedef enum logic [2:0] {StIdle, StRd, StWt, StWr, StFin} state_e;

    localparam logic [1:0] LastWt = 2'(READ_LATENCY - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, dst_q;
    logic [ADDR_W:0]     remain_q;
    logic [1:0]          mode_q;
    logic [7:0]          param_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   proc_word;
    logic [1:0]          wt_cnt_q;

    function automatic logic [7:0] pix_op(input logic [7:0] p, input logic [1:0] m,
                                          input logic [7:0] k);
        logic [8:0] sum;
        sum = {1'b0, p} + {1'b0, k};
        case (m)
            2'b00:   return p;
            2'b01:   return 8'hFF - p;
            2'b10:   return (p >= k) ? 8'hFF : 8'h00;
            default: return sum[8] ? 8'hFF : sum[7:0];
        endcase
    endfunction

    always_comb begin
        proc_word = '0;
        for (int i = 0; i < 4; i++) begin
            proc_word[8*i +: 8] = pix_op(rdata_q[8*i +: 8], mode_q, param_q);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = (word_count == '0) ? StFin : StRd;
            StRd:   state_d = StWt;
            StWt:   if (wt_cnt_q == LastWt) state_d = StWr;
            StWr:   state_d = (remain_q == 1) ? StFin : StRd;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy           = (state_q == StRd) || (state_q == StWt) || (state_q == StWr);
        done           = (state_q == StFin);
        mem_chipselect = (state_q == StRd) || (state_q == StWr);
        mem_write      = (state_q == StWr);
        mem_byteenable = mem_chipselect ? 4'hF : 4'h0;
        mem_writedata  = (state_q == StWr) ? proc_word : '0;
        mem_clken      = 1'b1;
        mem_address    = '0;
        if (state_q == StRd) mem_address = src_q;
        if (state_q == StWr) mem_address = dst_q;
    end

`ifdef ONCHIP_PIXEL_ENGINE_STATS_EN
    logic [7:0] stat_min_d, stat_max_d;

    always_comb begin
        stat_min_d = stat_min;
        stat_max_d = stat_max;
        for (int i = 0; i < 4; i++) begin
            if (proc_word[8*i +: 8] < stat_min_d) stat_min_d = proc_word[8*i +: 8];
            if (proc_word[8*i +: 8] > stat_max_d) stat_max_d = proc_word[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_min <= 8'h00;
            stat_max <= 8'h00;
        end else if (state_q == StIdle && start) begin
            stat_min <= 8'hFF;
            stat_max <= 8'h00;
        end else if (state_q == StWr) begin
            stat_min <= stat_min_d;
            stat_max <= stat_max_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            src_q      <= '0;
            dst_q      <= '0;
            remain_q   <= '0;
            mode_q     <= '0;
            param_q    <= '0;
            rdata_q    <= '0;
            wt_cnt_q   <= '0;
            words_done <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        src_q      <= src_base;
                        dst_q      <= dst_base;
                        remain_q   <= word_count;
                        mode_q     <= mode;
                        param_q    <= param;
                        wt_cnt_q   <= '0;
                        words_done <= '0;
                    end
                end
                StWt: begin
                    if (wt_cnt_q == LastWt) begin
                        rdata_q  <= mem_readdata;
                        wt_cnt_q <= '0;
                    end else begin
                        wt_cnt_q <= wt_cnt_q + 2'd1;
                    end
                end
                StWr: begin
                    // Pointers wrap modulo the RAM depth by natural overflow.
                    src_q      <= src_q + 1'b1;
                    dst_q      <= dst_q + 1'b1;
                    remain_q   <= remain_q - 1'b1;
                    words_done <= words_done + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_pixel_engine.sv
// Self-checking bench for onchip_pixel_engine: RAM model on s2, directed and random jobs vs a
// per-pixel reference model.
module tb_onchip_pixel_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] src_base = '0;
    logic [11:0] dst_base = '0;
    logic [12:0] word_count = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  param = '0;
    logic        busy, done;
    logic [12:0] words_done;
    logic [11:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
`ifdef ONCHIP_PIXEL_ENGINE_STATS_EN
    logic [7:0]  stat_min, stat_max;
`endif

    onchip_pixel_engine dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .src_base       (src_base),
        .dst_base       (dst_base),
        .word_count     (word_count),
        .mode           (mode),
        .param          (param),
        .busy           (busy),
        .done           (done),
        .words_done     (words_done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .mem_clken      (mem_clken)
`ifdef ONCHIP_PIXEL_ENGINE_STATS_EN
        ,
        .stat_min       (stat_min),
        .stat_max       (stat_max)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] ram[4096];
    logic [31:0] exp_mem[4096];
    logic [11:0] rd_q[$];
    logic [11:0] wr_q[$];
    int          cs_cnt = 0;
    int          exp_min = 0;
    int          exp_max = 0;
    int          checks = 0;
    int          errors = 0;

    // Single-cycle-latency RAM on port s2.
    always @(posedge clk) begin
        if (mem_chipselect) begin
            cs_cnt = cs_cnt + 1;
            if (mem_write) begin
                ram[mem_address] = mem_writedata;
                wr_q.push_back(mem_address);
            end else begin
                mem_readdata <= ram[mem_address];
                rd_q.push_back(mem_address);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pix(input int p, input int m, input int k);
        case (m)
            0:       return p;
            1:       return 255 - p;
            2:       return (p >= k) ? 255 : 0;
            default: return (p + k > 255) ? 255 : p + k;
        endcase
    endfunction

    function automatic logic [31:0] word_op(input logic [31:0] w, input int m, input int k);
        logic [31:0] r;
        int          v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            v = pix(int'(w[8*i +: 8]), m, k);
            r[8*i +: 8] = 8'(v);
        end
        return r;
    endfunction

    // Reference: words processed in ascending order, each read before written.
    task automatic model_job(input int src, input int dst, input int cnt, input int m, input int k);
        logic [31:0] w;
        exp_min = 255;
        exp_max = 0;
        for (int i = 0; i < cnt; i++) begin
            w = word_op(exp_mem[(src + i) % 4096], m, k);
            exp_mem[(dst + i) % 4096] = w;
            for (int b = 0; b < 4; b++) begin
                if (int'(w[8*b +: 8]) < exp_min) exp_min = int'(w[8*b +: 8]);
                if (int'(w[8*b +: 8]) > exp_max) exp_max = int'(w[8*b +: 8]);
            end
        end
    endtask

    function automatic int mem_diff();
        int d = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== exp_mem[i]) d++;
        return d;
    endfunction

    task automatic run_job(input int src, input int dst, input int cnt, input int m, input int k,
                           input bit restart, output int cyc);
        int bad;
        @(negedge clk);
        src_base   = 12'(src);
        dst_base   = 12'(dst);
        word_count = 13'(cnt);
        mode       = 2'(m);
        param      = 8'(k);
        start      = 1'b1;
        rd_q.delete();
        wr_q.delete();
        cs_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 20000) begin
            start = (restart && cyc == 5);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        model_job(src, dst, cnt, m, k);
        check("words_done", words_done, 32'(cnt));
        check("write_count", wr_q.size(), cnt);
        check("read_count", rd_q.size(), cnt);
        bad = 0;
        for (int i = 0; i < cnt; i++) begin
            if (i < rd_q.size() && rd_q[i] != 12'((src + i) % 4096)) bad++;
            if (i < wr_q.size() && wr_q[i] != 12'((dst + i) % 4096)) bad++;
        end
        check("addr_order", bad, 0);
        check("mem_diff", mem_diff(), 0);
`ifdef ONCHIP_PIXEL_ENGINE_STATS_EN
        check("stat_min", stat_min, 32'(exp_min));
        check("stat_max", stat_max, 32'(exp_max));
`endif
    endtask

    task automatic preload(input int addr, input logic [31:0] w);
        ram[addr]     = w;
        exp_mem[addr] = w;
    endtask

    initial begin
        int cyc;
        int s, d, n;
        for (int i = 0; i < 4096; i++) preload(i, $urandom);

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cs", mem_chipselect, 0);
        check("rst_write", mem_write, 0);
        check("rst_addr", mem_address, 0);
        check("rst_wdata", mem_writedata, 0);
        check("rst_words_done", words_done, 0);
`ifdef ONCHIP_PIXEL_ENGINE_STATS_EN
        check("rst_stat_min", stat_min, 0);
        check("rst_stat_max", stat_max, 0);
`endif
        reset_n = 1'b1;

        // Invert block of four.
        preload(16'h010, 32'h00FF7F80);
        preload(16'h011, 32'h01020304);
        preload(16'h012, 32'h10203040);
        preload(16'h013, 32'hFFFFFFFF);
        run_job(12'h010, 12'h100, 4, 1, 0, 1'b0, cyc);
        check("inv_latency", cyc, 13);
        check("inv_w0", ram[12'h100], 32'hFF00807F);
        check("inv_w1", ram[12'h101], 32'hFEFDFCFB);
        check("inv_w2", ram[12'h102], 32'hEFDFCFBF);
        check("inv_w3", ram[12'h103], 32'h00000000);

        preload(12'h020, 32'h7F80FF00);
        run_job(12'h020, 12'h120, 1, 2, 8'h80, 1'b0, cyc);
        check("thresh_w", ram[12'h120], 32'h00FFFF00);
        check("thresh_latency", cyc, 4);

        preload(12'h030, 32'hF0E01000);
        run_job(12'h030, 12'h130, 1, 3, 8'h20, 1'b0, cyc);
        check("bright_w", ram[12'h130], 32'hFFFF3020);

        run_job(12'hFFE, 12'h7FE, 4, 0, 0, 1'b0, cyc);
        check("wrap_rd2", (rd_q.size() > 2) ? 32'(rd_q[2]) : 32'hDEAD, 0);
        check("wrap_wr3", (wr_q.size() > 3) ? 32'(wr_q[3]) : 32'hDEAD, 12'h801);

        run_job(12'h050, 12'h150, 0, 1, 0, 1'b0, cyc);
        check("zero_latency", cyc, 1);
        check("zero_cs", cs_cnt, 0);
`ifdef ONCHIP_PIXEL_ENGINE_STATS_EN
        check("zero_stat_min", stat_min, 8'hFF);
        check("zero_stat_max", stat_max, 8'h00);
`endif

        // Second start during the job must be ignored.
        run_job(12'h200, 12'h300, 4, 1, 0, 1'b1, cyc);
        check("restart_latency", cyc, 13);

`ifdef ONCHIP_PIXEL_ENGINE_STATS_EN
        preload(12'h040, 32'h05FA3C11);
        run_job(12'h040, 12'h140, 1, 0, 0, 1'b0, cyc);
        check("stat_min_spec", stat_min, 8'h05);
        check("stat_max_spec", stat_max, 8'hFA);
`endif

        // Reset during the wait cycle of word 2 of 8.
        @(negedge clk);
        src_base   = 12'h500;
        dst_base   = 12'h600;
        word_count = 13'd8;
        mode       = 2'd1;
        start      = 1'b1;
        rd_q.delete();
        wr_q.delete();
        cs_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_cs", mem_chipselect, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_mem[12'h600] = word_op(exp_mem[12'h500], 1, 0);
        check("abort_writes", wr_q.size(), 1);
        check("abort_cs_total", cs_cnt, 3);
        check("abort_words_done", words_done, 0);
        check("abort_mem_diff", mem_diff(), 0);
`ifdef ONCHIP_PIXEL_ENGINE_STATS_EN
        check("abort_stat_min", stat_min, 0);
`endif

        // Random jobs, some with overlapping windows.
        for (int t = 0; t < 12; t++) begin
            if (t % 3 == 0) begin
                s = 12'h400 + $urandom_range(0, 16);
                d = 12'h400 + $urandom_range(0, 16);
            end else begin
                s = $urandom_range(0, 4095);
                d = $urandom_range(0, 4095);
            end
            n = $urandom_range(1, 24);
            run_job(s, d, n, $urandom_range(0, 3), $urandom_range(0, 255), t[0], cyc);
            check("rand_latency", cyc, 3 * n + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
